fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_mux.sv | 36 +++
 rtl/fetch.sv | 58 +++++
 tb/tb_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the redirect-target encodings and the sequential PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      SEL_IMD2EXT = 2'b00,
      SEL_REGA    = 2'b01,
      SEL_INDEX   = 2'b10,
      SEL_EXC     = 2'b11
   } sel_pc_e;

   localparam int unsigned PC_W   = 32;
   localparam logic [31:0] PC_INC = 32'd4;

endpackage : fetch_pkg

// File: rtl/fetch_pc_mux.sv
// Next-PC selection for fetch: a 4:1 redirect-target mux followed by a
// sequential/redirect choice. Purely combinational.
module fetch_pc_mux
   import fetch_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'd64
) (
   input  logic [31:0] pc,
   input  logic        selpcsource,
   input  sel_pc_e     selpctype,
   input  logic [31:0] pcimd2ext,
   input  logic [31:0] rega,
   input  logic [31:0] pcindex,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic [31:0] target;

   // Wraps modulo 2^32; targets are used exactly as supplied.
   assign pc_plus4 = pc + PC_INC;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      target = pcimd2ext;
      unique case (selpctype)
         SEL_IMD2EXT: target = pcimd2ext;
         SEL_REGA:    target = rega;
         SEL_INDEX:   target = pcindex;
         SEL_EXC:     target = EXC_VECTOR;
      endcase
   end

   assign next_pc = selpcsource ? target : pc_plus4;

endmodule : fetch_pc_mux

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory read,
// and registers the fetched word and its PC+4 toward decode.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'd64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_if_stall,
   input  logic        id_if_selpcsource,
   input  logic [1:0]  id_if_selpctype,
   input  logic [31:0] id_if_rega,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_pcindex,
   input  logic [31:0] mc_if_data,
   output logic        if_mc_en,
   output logic [31:0] if_mc_addr,
   output logic [31:0] if_id_nextpc,
   output logic [31:0] if_id_instruc
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   fetch_pc_mux #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_mux (
      .pc          (pc),
      .selpcsource (id_if_selpcsource),
      .selpctype   (sel_pc_e'(id_if_selpctype)),
      .pcimd2ext   (id_if_pcimd2ext),
      .rega        (id_if_rega),
      .pcindex     (id_if_pcindex),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc)
   );

   assign if_mc_addr = pc;
   assign if_mc_en   = reset & ~ex_if_stall;

   // Reset is tested first so an unknown stall or redirect cannot reach state while it is held.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register updates from the values present before the edge.
      if (!reset) begin
         pc            <= RESET_PC;
         if_id_instruc <= '0;
         if_id_nextpc  <= '0;
      end else if (!ex_if_stall) begin
         pc            <= next_pc;
         if_id_instruc <= mc_if_data;
         if_id_nextpc  <= pc_plus4;
      end
   end

endmodule : fetch

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: the driver updates a behavioural model and
// queues expected outputs; a monitor pops and compares after each edge.
module tb_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_if_stall;
   logic        id_if_selpcsource;
   logic [1:0]  id_if_selpctype;
   logic [31:0] id_if_rega;
   logic [31:0] id_if_pcimd2ext;
   logic [31:0] id_if_pcindex;
   logic [31:0] mc_if_data;
   logic        if_mc_en;
   logic [31:0] if_mc_addr;
   logic [31:0] if_id_nextpc;
   logic [31:0] if_id_instruc;

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic [31:0] nextpc;
      logic [31:0] instruc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [31:0] m_pc, m_nextpc, m_instruc;

   fetch dut (
      .clock             (clock),
      .reset             (reset),
      .ex_if_stall       (ex_if_stall),
      .id_if_selpcsource (id_if_selpcsource),
      .id_if_selpctype   (id_if_selpctype),
      .id_if_rega        (id_if_rega),
      .id_if_pcimd2ext   (id_if_pcimd2ext),
      .id_if_pcindex     (id_if_pcindex),
      .mc_if_data        (mc_if_data),
      .if_mc_en          (if_mc_en),
      .if_mc_addr        (if_mc_addr),
      .if_id_nextpc      (if_id_nextpc),
      .if_id_instruc     (if_id_instruc)
   );

   always #5 clock = ~clock;

   // Instruction memory: a fixed word at address 8, a scrambled address elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd8) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   assign mc_if_data = mem_word(if_mc_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus, applied on the falling edge; the model follows the
   // fetch rules directly and queues what the DUT should show after the next rising edge.
   task automatic drive(input logic r, input logic s, input logic src, input logic [1:0] ty,
                        input logic [31:0] ra, input logic [31:0] imd, input logic [31:0] idx);
      logic [31:0] tgt [4];
      exp_t e;
      @(negedge clock);
      reset = r; ex_if_stall = s; id_if_selpcsource = src; id_if_selpctype = ty;
      id_if_rega = ra; id_if_pcimd2ext = imd; id_if_pcindex = idx;
      tgt = '{imd, ra, idx, 32'd64};
      e.en = (r === 1'b1) && (s === 1'b0);
      if (r === 1'b0) begin
         m_pc = 32'h0; m_instruc = 32'h0; m_nextpc = 32'h0;
      end else if (s === 1'b0) begin
         m_instruc = mem_word(m_pc);
         m_nextpc  = m_pc + 32'd4;
         m_pc      = (src === 1'b1) ? tgt[ty] : m_pc + 32'd4;
      end
      e.addr = m_pc; e.nextpc = m_nextpc; e.instruc = m_instruc;
      sb_q.push_back(e);
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic jump(input logic [31:0] a);
      drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0, a);
   endtask

   // Monitor: compares the oldest expectation shortly after each rising edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("if_mc_en",      {31'b0, if_mc_en}, {31'b0, e.en});
            check("if_mc_addr",    if_mc_addr,        e.addr);
            check("if_id_nextpc",  if_id_nextpc,      e.nextpc);
            check("if_id_instruc", if_id_instruc,     e.instruc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; ex_if_stall = 1'b0; id_if_selpcsource = 1'b0; id_if_selpctype = 2'b00;
      id_if_rega = '0; id_if_pcimd2ext = '0; id_if_pcindex = '0;
      m_pc = '0; m_nextpc = '0; m_instruc = '0;

      // Reset for two cycles with unknown stall and redirect.
      drive(1'b0, 1'bx, 1'bx, 2'bxx, 32'h0, 32'h0, 32'h0);
      drive(1'b0, 1'bx, 1'bx, 2'b11, 32'h0, 32'h0, 32'h0);

      // Sequential fetch through address 8 (DEADBEEF) and beyond.
      seq(5);

      // Each redirect type.
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, 1'b0, 1'b1, 2'(t), 32'h200, 32'h100, 32'h300);
         seq(1);
      end

      // Five-cycle stall at 0x20 with a redirect held, then release.
      jump(32'h20);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h200, 32'h100, 32'h300);
      drive(1'b1, 1'b0, 1'b1, 2'b01, 32'h200, 32'h100, 32'h300);
      seq(2);

      // Reset arriving during a stall at 0x40.
      jump(32'h40);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h200, 32'h0, 32'h0);
      seq(2);

      // Wrap from the top of the address space.
      jump(32'hFFFF_FFFC);
      seq(3);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(99) >= 3), ($urandom_range(99) < 25), ($urandom_range(99) < 30),
               2'($urandom_range(3)), $urandom, $urandom, $urandom);
      end

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
      if (sb_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_fetch
